// File: rtl/reg_file_pkg.sv
// Shared constants, address type and packed-bus slicing helpers for the register file.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  // Low bit of port 'port' in a packed multi-port bus of 'width'-bit lanes.
  function automatic int unsigned lo_bit(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

  // An address is live when it names real storage: in range and not the hardwired zero.
  function automatic logic addr_live(input int unsigned addr, input int unsigned nregs,
                                     input int unsigned zero_reg);
    return (addr < nregs) && !((zero_reg != 0) && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register write-pending scoreboard: busy vector with flush > set > clear priority.
// Latency: busy updates one cycle after issue/write; issue_ok is combinational.
// Backpressure: issue_ok=0 refuses an issue to a register whose producer is still in flight.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  input  logic              flush,
  output logic [NREGS-1:0]  busy,
  output logic              issue_ok
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr;
  logic [NREGS-1:0] set;
  logic [AW-1:0]    wa;
  logic             issue_live;
  logic             issue_hit_wr;

  // Writebacks clear busy; an accepted issue sets it and beats a same-cycle writeback,
  // since that writeback retires the older producer. Flush wipes everything.
  always_comb begin
    clr          = '0;
    set          = '0;
    wa           = '0;
    issue_hit_wr = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      wa = wr_addr[lo_bit(j, AW) +: AW];
      if (wr_en[j] && addr_live(32'(wa), NREGS, ZERO_REG)) begin
        clr[wa] = 1'b1;
      end
      if (wr_en[j] && (wa == issue_addr)) begin
        issue_hit_wr = 1'b1;
      end
    end
    issue_live = addr_live(32'(issue_addr), NREGS, ZERO_REG);
    issue_ok   = issue_live ? (!flush && (!busy_q[issue_addr] || issue_hit_wr)) : 1'b1;
    if (issue_en && issue_ok && issue_live) begin
      set[issue_addr] = 1'b1;
    end
    busy_d = flush ? '0 : ((busy_q & ~clr) | set);
  end

  // Busy vector register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with optional x0, write-to-read bypass and busy scoreboard.
// Latency: reads combinational; writes visible next cycle (same cycle via bypass).
// Backpressure: ISSUE_OK gates new producers on busy destinations; reads report RD_READY.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NRD*AW-1:0]   RD_ADDR,
  output logic [NRD*XLEN-1:0] RD_DATA,
  output logic [NRD-1:0]      RD_READY,
  input  logic [NWR-1:0]      WR_EN,
  input  logic [NWR*AW-1:0]   WR_ADDR,
  input  logic [NWR*XLEN-1:0] WR_DATA,
  input  logic                ISSUE_EN,
  input  logic [AW-1:0]       ISSUE_ADDR,
  output logic                ISSUE_OK,
  input  logic                FLUSH,
  output logic [NREGS-1:0]    BUSY,
  output logic                WR_CONFLICT
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [AW-1:0]    wa     [NWR];
  logic [XLEN-1:0]  wd     [NWR];
  logic [NWR-1:0]   w_live;
  logic [NREGS-1:0] busy_vec;
  logic             conflict_d;
  logic             conflict_q;

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j]     = WR_ADDR[lo_bit(j, AW) +: AW];
    assign wd[j]     = WR_DATA[lo_bit(j, XLEN) +: XLEN];
    assign w_live[j] = WR_EN[j] & addr_live(32'(wa[j]), NREGS, ZERO_REG);
  end

  // Storage: ports applied in ascending order so the highest index lands last and wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_live[j]) begin
          regs_q[wa[j]] <= wd[j];
        end
      end
    end
  end

  // Any pair of live write ports aimed at the same register is a conflict.
  always_comb begin
    conflict_d = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (w_live[j] && w_live[k] && (wa[j] == wa[k])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Conflict flag is reported one cycle after the colliding writes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rrdy;

    assign ra = RD_ADDR[lo_bit(i, AW) +: AW];

    // Dead addresses read 0 and ready; otherwise stored value, overridden by the
    // highest-index same-cycle write when bypassing.
    always_comb begin
      rdat = '0;
      rrdy = 1'b1;
      if (addr_live(32'(ra), NREGS, ZERO_REG)) begin
        rdat = regs_q[ra];
        rrdy = !busy_vec[ra];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (w_live[j] && (wa[j] == ra)) begin
              rdat = wd[j];
              rrdy = 1'b1;
            end
          end
        end
      end
    end

    assign RD_DATA[lo_bit(i, XLEN) +: XLEN] = rdat;
    assign RD_READY[i]                      = rrdy;
  end

  reg_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .wr_en      (WR_EN),
    .wr_addr    (WR_ADDR),
    .issue_en   (ISSUE_EN),
    .issue_addr (ISSUE_ADDR),
    .flush      (FLUSH),
    .busy       (busy_vec),
    .issue_ok   (ISSUE_OK)
  );

  assign BUSY        = busy_vec;
  assign WR_CONFLICT = conflict_q;

endmodule
